// File: rtl/freq_meter_pkg.sv
// Shared constants, default widths and types for the reciprocal frequency meter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package freq_meter_pkg;

   localparam int PS_W = 40;
   localparam logic [PS_W-1:0] PS_PER_S = 40'd1_000_000_000_000;

   localparam int DEF_CNT_W     = 32;
   localparam int DEF_TDC_W     = 20;
   localparam int DEF_T_REF_PS  = 100000;
   localparam int DEF_FRAC_BITS = 8;
   localparam int DEF_OUT_W     = 48;

   typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

   // Fixed-point frequency word at the default output width.
   typedef logic [DEF_OUT_W-1:0] freq_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: start performs the first step; done pulses NUM_W-1 clocks later with quo final.
// Backpressure: none; start is ignored-safe only when idle, owner guarantees that.
module seq_divider #(
   parameter int NUM_W = 80,
   parameter int DEN_W = 51
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             done,
   output logic [NUM_W-1:0] quo
);
   localparam int CNT_BITS = $clog2(NUM_W + 1);

   logic [DEN_W-1:0]    rem;
   logic [DEN_W-1:0]    den_q;
   logic [CNT_BITS-1:0] cnt;
   logic                running;

   logic [DEN_W-1:0] src_rem;
   logic [NUM_W-1:0] src_quo;
   logic [DEN_W-1:0] cur_den;
   logic [DEN_W:0]   shifted;
   logic             ge;
   logic [DEN_W-1:0] diff;
   logic [DEN_W-1:0] rem_next;
   logic [NUM_W-1:0] quo_next;

   // One restoring step; on start the step works straight from the new operands.
   always_comb begin
      src_rem  = start ? '0  : rem;
      src_quo  = start ? num : quo;
      cur_den  = start ? den : den_q;
      shifted  = {src_rem, src_quo[NUM_W-1]};
      ge       = shifted >= {1'b0, cur_den};
      diff     = shifted[DEN_W-1:0] - cur_den;
      rem_next = ge ? diff : shifted[DEN_W-1:0];
      quo_next = {src_quo[NUM_W-2:0], ge};
   end

   // Iteration state: quo doubles as the numerator shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         den_q   <= '0;
         quo     <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem     <= rem_next;
            quo     <= quo_next;
            den_q   <= den;
            cnt     <= CNT_BITS'(NUM_W - 1);
            running <= 1'b1;
         end else if (running) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_BITS'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/freq_calc.sv
// Reciprocal-count frequency: freq_hz = meas_cnt*1e12/T_ps in Q(OUT_W-FRAC_BITS).FRAC_BITS Hz; optional averaging under FREQ_AVG_EN.
// Latency: out_valid NUM_W+2 clocks after accept (82 default), 2 clocks on invalid input.
// Backpressure: none; in_valid while busy (including DONE) is dropped and sets sticky overrun.
module freq_calc
   import freq_meter_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TDC_W     = DEF_TDC_W,
   parameter int T_REF_PS  = DEF_T_REF_PS,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int OUT_W     = DEF_OUT_W
`ifdef FREQ_AVG_EN
   , parameter int AVG_LOG2 = 2
`endif
)(
   input  logic             clk_ref,
   input  logic             sys_rst,
   input  logic             in_valid,
   input  logic [CNT_W-1:0] ref_cnt,
   input  logic [CNT_W-1:0] meas_cnt,
   input  logic [TDC_W-1:0] t_start_ps,
   input  logic [TDC_W-1:0] t_stop_ps,
   output logic             busy,
   output logic             out_valid,
   output logic [OUT_W-1:0] freq_hz,
   output logic             err,
   output logic             sat,
   output logic             overrun
);
   localparam int NUM_W = CNT_W + PS_W + FRAC_BITS;
   localparam int DEN_W = CNT_W + 17 + 2;

   state_t           state;
   logic [CNT_W-1:0] ref_q;
   logic [CNT_W-1:0] meas_q;
   logic [TDC_W-1:0] tstart_q;
   logic [TDC_W-1:0] tstop_q;
   logic             err_q;

   logic [DEN_W-1:0] t_ps;
   logic [NUM_W-1:0] num;
   logic             bad;
   logic             div_start;
   logic             div_done;
   logic [NUM_W-1:0] quo;
   logic             fits;
   logic [OUT_W-1:0] res;

   // Gate period in ps (two's complement) and scaled numerator from the captured snapshot.
   assign t_ps      = DEN_W'(ref_q) * DEN_W'(T_REF_PS) + DEN_W'(tstart_q) - DEN_W'(tstop_q);
   assign num       = (NUM_W'(meas_q) * NUM_W'(PS_PER_S)) << FRAC_BITS;
   assign bad       = (meas_q == '0) || t_ps[DEN_W-1] || (t_ps == '0);
   assign div_start = (state == LOAD) && !bad;
   assign fits      = (quo[NUM_W-1:OUT_W] == '0);
   assign res       = fits ? quo[OUT_W-1:0] : '1;

   seq_divider #(
      .NUM_W (NUM_W),
      .DEN_W (DEN_W)
   ) u_div (
      .clk   (clk_ref),
      .rst   (sys_rst),
      .start (div_start),
      .num   (num),
      .den   (t_ps),
      .done  (div_done),
      .quo   (quo)
   );

`ifdef FREQ_AVG_EN
   logic [OUT_W+AVG_LOG2-1:0] acc;
   logic [AVG_LOG2-1:0]       acc_cnt;
   logic                      acc_sat;
   logic [OUT_W+AVG_LOG2-1:0] acc_next;
   assign acc_next = acc + {{AVG_LOG2{1'b0}}, res};
`endif

   // Control FSM with registered result, status and sticky overrun.
   always_ff @(posedge clk_ref or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         ref_q     <= '0;
         meas_q    <= '0;
         tstart_q  <= '0;
         tstop_q   <= '0;
         err_q     <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         freq_hz   <= '0;
         err       <= 1'b0;
         sat       <= 1'b0;
         overrun   <= 1'b0;
`ifdef FREQ_AVG_EN
         acc       <= '0;
         acc_cnt   <= '0;
         acc_sat   <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         if (in_valid && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ref_q    <= ref_cnt;
                  meas_q   <= meas_cnt;
                  tstart_q <= t_start_ps;
                  tstop_q  <= t_stop_ps;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               err_q <= bad;
               state <= bad ? DONE : DIV;
            end
            DIV: begin
               if (div_done)
                  state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
`ifdef FREQ_AVG_EN
               if (err_q) begin
                  out_valid <= 1'b1;
                  freq_hz   <= '0;
                  err       <= 1'b1;
                  sat       <= 1'b0;
                  acc       <= '0;
                  acc_cnt   <= '0;
                  acc_sat   <= 1'b0;
               end else if (acc_cnt == '1) begin
                  out_valid <= 1'b1;
                  freq_hz   <= acc_next[OUT_W+AVG_LOG2-1:AVG_LOG2];
                  err       <= 1'b0;
                  sat       <= acc_sat | !fits;
                  acc       <= '0;
                  acc_cnt   <= '0;
                  acc_sat   <= 1'b0;
               end else begin
                  acc       <= acc_next;
                  acc_cnt   <= acc_cnt + 1'b1;
                  acc_sat   <= acc_sat | !fits;
               end
`else
               out_valid <= 1'b1;
               err       <= err_q;
               freq_hz   <= err_q ? '0 : res;
               sat       <= !err_q && !fits;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: exact, TDC-corrected, error, saturation, overrun and reset-abort cases.
// Latency: checks out_valid arrives 82 clocks after accept (2 on error).
// Backpressure: drives in_valid while busy and expects it to be dropped.
module tb_freq_calc;
   import freq_meter_pkg::*;

   logic        clk_ref = 1'b0;
   logic        sys_rst;
   logic        in_valid;
   logic [31:0] ref_cnt;
   logic [31:0] meas_cnt;
   logic [19:0] t_start_ps;
   logic [19:0] t_stop_ps;
   logic        busy;
   logic        out_valid;
   freq_t       freq_hz;
   logic        err;
   logic        sat;
   logic        overrun;

   int checks   = 0;
   int failures = 0;
   int lat;
   int pulses;

   freq_calc dut (
      .clk_ref    (clk_ref),
      .sys_rst    (sys_rst),
      .in_valid   (in_valid),
      .ref_cnt    (ref_cnt),
      .meas_cnt   (meas_cnt),
      .t_start_ps (t_start_ps),
      .t_stop_ps  (t_stop_ps),
      .busy       (busy),
      .out_valid  (out_valid),
      .freq_hz    (freq_hz),
      .err        (err),
      .sat        (sat),
      .overrun    (overrun)
   );

   always #5 clk_ref = ~clk_ref;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Called #1 after an edge; in_valid is sampled at the next edge (edge k).
   task automatic launch(input logic [31:0] r, input logic [31:0] m, input logic [19:0] ts, input logic [19:0] tp);
      ref_cnt    = r;
      meas_cnt   = m;
      t_start_ps = ts;
      t_stop_ps  = tp;
      in_valid   = 1'b1;
      @(posedge clk_ref);
      #1;
      in_valid   = 1'b0;
   endtask

   // Edges after the current one until out_valid is seen; -1 on timeout.
   task automatic wait_result(output int l);
      l = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk_ref);
         #1;
         if (out_valid) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int n, output int p);
      p = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_ref);
         #1;
         if (out_valid) p++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      sys_rst    = 1'b1;
      in_valid   = 1'b0;
      ref_cnt    = '0;
      meas_cnt   = '0;
      t_start_ps = '0;
      t_stop_ps  = '0;
      repeat (3) @(posedge clk_ref);
      #1;
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_freq", freq_hz, 0);
      check("rst_err", err, 0);
      check("rst_sat", sat, 0);
      check("rst_overrun", overrun, 0);
      sys_rst = 1'b0;
      @(posedge clk_ref);
      #1;

      // 10 MHz exact
      launch(100000, 100000, 0, 0);
      check("exact_busy_after_accept", busy, 1);
      wait_result(lat);
      check("exact_latency", lat, 82);
      check("exact_freq", freq_hz, 64'd2560000000);
      check("exact_err", err, 0);
      check("exact_sat", sat, 0);
      check("exact_busy_at_done", busy, 0);

      // TDC correction, accepted in the cycle right after DONE
      launch(100000, 100000, 30000, 10000);
      wait_result(lat);
      check("tdc_latency", lat, 82);
      check("tdc_freq", freq_hz, 64'd2559994880);
      check("tdc_err", err, 0);
      repeat (5) @(posedge clk_ref);
      #1;
      check("hold_out_valid_low", out_valid, 0);
      check("hold_freq", freq_hz, 64'd2559994880);

      // zero measured count
      launch(100000, 0, 0, 0);
      wait_result(lat);
      check("meas0_latency", lat, 2);
      check("meas0_err", err, 1);
      check("meas0_freq", freq_hz, 0);
      check("meas0_sat", sat, 0);

      // zero period
      launch(0, 100000, 500, 500);
      wait_result(lat);
      check("t0_latency", lat, 2);
      check("t0_err", err, 1);
      check("t0_freq", freq_hz, 0);

      // saturation with T = 1 ps
      launch(0, 32'hFFFF_FFFF, 1, 0);
      wait_result(lat);
      check("sat_latency", lat, 82);
      check("sat_flag", sat, 1);
      check("sat_err", err, 0);
      check("sat_freq", freq_hz, 64'hFFFF_FFFF_FFFF);
      check("no_overrun_yet", overrun, 0);

      // overrun: second request 10 cycles after the first
      launch(100000, 100000, 0, 0);
      repeat (9) @(posedge clk_ref);
      #1;
      launch(100000, 50000, 0, 0);
      check("overrun_set", overrun, 1);
      wait_result(lat);
      check("overrun_first_latency", lat, 72);
      check("overrun_first_freq", freq_hz, 64'd2560000000);
      check("overrun_first_err", err, 0);
      check("overrun_busy_after", busy, 0);
      count_pulses(120, pulses);
      check("overrun_dropped", pulses, 0);
      check("overrun_sticky", overrun, 1);

      // reset 20 cycles into DIV
      launch(100000, 100000, 0, 0);
      repeat (21) @(posedge clk_ref);
      #1;
      sys_rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_overrun_cleared", overrun, 0);
      @(posedge clk_ref);
      #1;
      sys_rst = 1'b0;
      count_pulses(100, pulses);
      check("abort_no_result", pulses, 0);
      launch(100000, 100000, 30000, 10000);
      wait_result(lat);
      check("after_abort_latency", lat, 82);
      check("after_abort_freq", freq_hz, 64'd2559994880);
      check("after_abort_err", err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/freq_calc.md
Name: freq_calc

Overview:
- Downstream of the gate/counter stage.
- Consumes one snapshot per gate window: reference count, measured count, and the two TDC fine-time results (gate-open phase, gate-close phase).
- Computes reciprocal-count frequency f = meas_cnt * 1e12 / T_ps, where T_ps = ref_cnt*T_REF_PS + t_start_ps - t_stop_ps.
- Result is fixed-point Hz, computed with a multi-cycle restoring divider and delivered on a valid pulse to the readout logic.

Parameters:
- CNT_W, 32, width of ref_cnt and meas_cnt
- TDC_W, 20, width of each TDC fine-time input (ps, unsigned)
- T_REF_PS, 100000, reference clock period in ps (10 MHz)
- FRAC_BITS, 8, fractional bits of freq_hz
- OUT_W, 48, width of freq_hz (integer part = OUT_W-FRAC_BITS)

Ports:
- clk_ref  in  1  reference clock; all logic on posedge
- sys_rst  in  1  asynchronous active-high reset
- in_valid  in  1  one-cycle pulse: snapshot inputs valid
- ref_cnt  in  CNT_W  reference cycles inside gate
- meas_cnt  in  CNT_W  measured cycles inside gate
- t_start_ps  in  TDC_W  TDC interval at gate open
- t_stop_ps  in  TDC_W  TDC interval at gate close
- busy  out  1  high from accept until out_valid
- out_valid  out  1  one-cycle result strobe
- freq_hz  out  OUT_W  frequency, unsigned Q(OUT_W-FRAC_BITS).FRAC_BITS
- err  out  1  qualified by out_valid: invalid input (zero count or T_ps<=0)
- sat  out  1  qualified by out_valid: quotient clipped
- overrun  out  1  sticky: in_valid arrived while busy

Behaviour:
- Reset (async, any state): busy=0, out_valid=0, freq_hz=0, err=0, sat=0, overrun=0, FSM=IDLE, divider registers cleared. Reset mid-division aborts; no out_valid follows.
- Derived constants: PS_PER_S=10^12 (40 bits). NUM_W=CNT_W+40+FRAC_BITS (80 by default). DEN_W=CNT_W+17+2 signed.
- IDLE:
  - in_valid=1 at edge k captures all inputs and sets busy. Go to LOAD.
- LOAD (edge k+1):
  - Compute T = ref_cnt*T_REF_PS + t_start_ps - t_stop_ps as a signed DEN_W-bit value.
  - Compute N = (meas_cnt*PS_PER_S) << FRAC_BITS.
  - If meas_cnt==0 or T<=0: go to DONE with err=1, freq_hz=0.
  - Otherwise go to DIV.
- DIV:
  - Restoring division, one quotient bit per clock, MSB first, exactly NUM_W iterations. Go to DONE.
- DONE:
  - out_valid=1 for one cycle and busy drops in the same cycle.
  - freq_hz = quotient if it fits in OUT_W bits; otherwise all-ones with sat=1.
  - Return to IDLE.
- Latency, normal path: out_valid at edge k+NUM_W+2 (82 with defaults). Error path: k+2.
- freq_hz and err/sat hold their values until the next DONE.
- in_valid while busy (including the DONE cycle): input dropped, overrun set; cleared only by reset.
- in_valid in the cycle after DONE (IDLE): accepted normally.
- Rounding: truncation toward zero.

Optional Feature:
- FREQ_AVG_EN
  - Defined: adds parameter AVG_LOG2 (default 2). Non-error results accumulate in an (OUT_W+AVG_LOG2)-bit register. out_valid fires only on every 2^AVG_LOG2-th good result, with freq_hz = sum>>AVG_LOG2 and sat = OR of the constituent sats.
  - An err result is reported immediately and clears the accumulator.
- Undefined: every result is reported individually.

Decomposition:
- Package freq_meter_pkg:
  - PS_PER_S
  - default widths (CNT_W, TDC_W)
  - T_REF_PS default
  - typedef enum of FSM states {IDLE, LOAD, DIV, DONE}
  - typedef for the fixed-point frequency word
- Sub-module seq_divider: parameterised (NUM_W, DEN_W), start/done handshake, unsigned restoring divider, one bit per cycle. freq_calc owns the FSM, the arithmetic setup and the saturation logic.

Test Plan:
- 10 MHz exact: ref_cnt=100000, meas_cnt=100000, t_start=t_stop=0 -> out_valid at accept+82, freq_hz=2560000000 (10_000_000.0 Hz), err=0, sat=0.
- TDC correction: same counts, t_start=30000, t_stop=10000 -> T=10000020000 ps, freq_hz=2559994880 (9999980.0 Hz).
- Errors:
  - meas_cnt=0 -> err=1, freq_hz=0 at accept+2.
  - ref_cnt=0, t_start=t_stop=500 -> err=1.
- Overrun: second in_valid 10 cycles after first -> first result correct, second dropped, overrun=1 until sys_rst; busy=0 after out_valid.
- Saturation: ref_cnt=0, meas_cnt=0xFFFFFFFF, t_start=1, t_stop=0 -> sat=1, freq_hz=all-ones.
- Reset mid-op: assert sys_rst 20 cycles into DIV -> busy=0, no out_valid; next in_valid produces a correct result.
